key_schedule_ctrl: RTL and testbench

//  Sequences the one-step key-expansion datapath (key_expand_step) over all AES rounds after a start request.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/key_expand_step.sv | 31 +++
 rtl/key_schedule_ctrl.sv | 126 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES key-schedule helpers, size formulas and controller state encoding
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } ks_state_e;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nr_of(nk) + 1);
    endfunction

    // ceil(NW/NK) - 1: the last step may produce words beyond NW, which are dropped
    function automatic int nstep_of(input int nk);
        return (nw_of(nk) + nk - 1) / nk - 1;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (254 = 8'b1111_1110); 0 maps to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    // S-box computed as inverse followed by the affine transform
    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] step);
        logic [7:0] r;
        case (step)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_expand_step.sv
// rtl/key_expand_step.sv - one combinational key-expansion step producing NK new words
module key_expand_step
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [3:0]       round,
    input  logic [32*NK-1:0] key,
    output logic [32*NK-1:0] keyOut
);

    logic [31:0] last_w;
    logic [31:0] acc;

    // Chain the NK words: word 0 takes RotWord/SubWord/Rcon, NK=8 adds SubWord at word 4
    always_comb begin
        keyOut = '0;
        last_w = key[31:0];
        acc    = key[32*NK-1 -: 32] ^ sub_word({last_w[23:0], last_w[31:24]})
                 ^ {rcon(round), 24'h000000};
        keyOut[32*NK-1 -: 32] = acc;
        for (int i = 1; i < NK; i++) begin
            if (NK == 8 && i == 4)
                acc = sub_word(acc) ^ key[32*(NK-1-i) +: 32];
            else
                acc = acc ^ key[32*(NK-1-i) +: 32];
            keyOut[32*(NK-1-i) +: 32] = acc;
        end
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - sequences key expansion and serves round keys as they complete
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*NK-1:0]  key_in,
    output logic              busy,
    output logic              done,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk_data,
    output logic              rk_valid
);

    localparam int NR    = nr_of(NK);
    localparam int NW    = nw_of(NK);
    localparam int NSTEP = nstep_of(NK);

    localparam logic [3:0] NR_L    = 4'(NR);
    localparam logic [3:0] NSTEP_L = 4'(NSTEP);
    localparam logic [6:0] NW_W    = 7'(NW);
    localparam logic [5:0] NW_C    = 6'(NW);
    localparam logic [6:0] NK_W    = 7'(NK);
    localparam logic [5:0] NK_C    = 6'(NK);

    ks_state_e        state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [5:0]       vcnt_q, vcnt_d;
    logic [32*NK-1:0] work_q, work_d;
    logic [32*NK-1:0] step_out;
    logic [6:0]       vsum;
    logic [5:0]       waddr [NK];
    logic [5:0]       rk_base;
    logic [31:0]      words_q [NW];

    key_expand_step #(.NK(NK)) u_step (
        .round  (step_q),
        .key    (work_q),
        .keyOut (step_out)
    );

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            vcnt_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            vcnt_q  <= vcnt_d;
            work_q  <= work_d;
        end
    end

    // Next-state, step/valid-count bookkeeping and status outputs
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        vcnt_d  = vcnt_q;
        work_d  = work_q;
        busy    = 1'b0;
        done    = 1'b0;
        vsum    = {1'b0, vcnt_q} + NK_W;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                work_d  = key_in;
                step_d  = 4'd1;
                vcnt_d  = NK_C;
                state_d = EXPAND;
            end
            EXPAND: begin
                busy   = 1'b1;
                work_d = step_out;
                vcnt_d = (vsum > NW_W) ? NW_C : vsum[5:0];
                if (step_q == NSTEP_L) state_d = DONE;
                else                   step_d  = step_q + 4'd1;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = LOAD;
                    vcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer slot for each of the NK words produced by the current step
    always_comb begin
        for (int i = 0; i < NK; i++) waddr[i] = 6'(int'(step_q) * NK + i);
    end

    // Word buffer: cipher key in LOAD, step output in EXPAND; slots past NW are dropped
    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            for (int i = 0; i < NK; i++) words_q[i] <= key_in[32*(NK-1-i) +: 32];
        end else if (state_q == EXPAND) begin
            for (int i = 0; i < NK; i++) begin
                if (waddr[i] < NW_C) words_q[waddr[i]] <= step_out[32*(NK-1-i) +: 32];
            end
        end
    end

    // Round-key read port: valid once all four words are written, zero otherwise
    always_comb begin
        rk_valid = 1'b0;
        rk_data  = '0;
        rk_base  = {rk_idx, 2'b00};
        if (rk_idx <= NR_L && {1'b0, vcnt_q} >= ({1'b0, rk_base} + 7'd4)) begin
            rk_valid = 1'b1;
            rk_data  = {words_q[rk_base], words_q[rk_base + 6'd1],
                        words_q[rk_base + 6'd2], words_q[rk_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - directed self-checking bench for key_schedule_ctrl (NK=4/6/8)
module tb_key_schedule_ctrl;

    localparam logic [127:0] K4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key4 = K4;
    logic [191:0] key6 = K6;
    logic [255:0] key8 = K8;
    logic [3:0]   rk_idx4 = 4'd0, rk_idx6 = 4'd0, rk_idx8 = 4'd0;
    logic         busy4, busy6, busy8, done4, done6, done8;
    logic         rk_valid4, rk_valid6, rk_valid8;
    logic [127:0] rk_data4, rk_data6, rk_data8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    key_schedule_ctrl #(.NK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key4), .busy(busy4), .done(done4),
        .rk_idx(rk_idx4), .rk_data(rk_data4), .rk_valid(rk_valid4)
    );
    key_schedule_ctrl #(.NK(6)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key6), .busy(busy6), .done(done6),
        .rk_idx(rk_idx6), .rk_data(rk_data6), .rk_valid(rk_valid6)
    );
    key_schedule_ctrl #(.NK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key8), .busy(busy8), .done(done8),
        .rk_idx(rk_idx8), .rk_data(rk_data8), .rk_valid(rk_valid8)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start is sampled on the rising edge inside; returns 1 time unit after that edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges counted from the caller's position until each done rises (0 = never seen)
    task automatic wait_done(output int l4, output int l6, output int l8);
        l4 = 0; l6 = 0; l8 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done4 && l4 == 0) l4 = c;
            if (done6 && l6 == 0) l6 = c;
            if (done8 && l8 == 0) l8 = c;
            if (l4 != 0 && l6 != 0 && l8 != 0) break;
        end
    endtask

    int           lat4, lat6, lat8, first;
    logic [127:0] got;
    int           ks [5] = '{0, 1, 2, 5, 10};
    logic [127:0] kexp [5];

    initial begin
        kexp[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        kexp[1] = 128'ha0fafe1788542cb123a339392a6c7605;
        kexp[2] = 128'hf2c295f27a96b9435935807a7359f67f;
        kexp[3] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        kexp[4] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", busy4, 1'b0);
        chk1("rst_done", done4, 1'b0);
        chk1("rst_rk_valid", rk_valid4, 1'b0);
        chk("rst_rk_data", rk_data4, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // full expansion, all three key sizes
        pulse_start();
        chk1("load_busy", busy4, 1'b1);
        chk1("load_rk0_not_valid", rk_valid4, 1'b0);
        wait_done(lat4, lat6, lat8);
        chki("lat_nk4", lat4, 11);
        chki("lat_nk6", lat6, 9);
        chki("lat_nk8", lat8, 8);
        chk1("done_busy", busy4, 1'b0);
        rk_idx4 = 4'd1; rk_idx6 = 4'd12; rk_idx8 = 4'd14;
        #1;
        chk("nk4_rk1", rk_data4, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("nk6_rk12", rk_data6, 128'he98ba06f448c773c8ecc720401002202);
        chk1("nk6_rk12_valid", rk_valid6, 1'b1);
        chk("nk8_rk14", rk_data8, 128'hfe4890d1e6188d0b046df344706c631e);
        rk_idx4 = 4'd10; rk_idx6 = 4'd0; rk_idx8 = 4'd1;
        #1;
        chk("nk4_rk10", rk_data4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk1("nk4_rk10_valid", rk_valid4, 1'b1);
        chk("nk6_rk0", rk_data6, 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("nk8_rk1", rk_data8, 128'h1f352c073b6108d72d9810a30914dff4);
        repeat (3) @(posedge clk);
        #1;
        chk1("done_held", done4, 1'b1);

        // overlap: key k readable exactly k+1 edges after start is sampled
        for (int j = 0; j < 5; j++) begin
            rk_idx4 = 4'(ks[j]);
            pulse_start();
            chk1("rekey_clears_done", done4, 1'b0);
            chk1("rekey_clears_valid", rk_valid4, 1'b0);
            first = 0;
            got = '0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
                if (rk_valid4 && first == 0) begin
                    first = c;
                    got = rk_data4;
                end
            end
            chki($sformatf("ovl_rise_k%0d", ks[j]), first, ks[j] + 1);
            chk($sformatf("ovl_data_k%0d", ks[j]), got, kexp[j]);
        end

        // start held high for 5 cycles in EXPAND is ignored
        pulse_start();
        lat4 = 0; lat6 = 0; lat8 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) start = 1'b1;
            if (c == 8) start = 1'b0;
            if (done4 && lat4 == 0) lat4 = c;
            if (done6 && lat6 == 0) lat6 = c;
            if (done8 && lat8 == 0) lat8 = c;
            if (lat4 != 0 && lat6 != 0) break;
        end
        chki("hold_lat_nk4", lat4, 11);
        chki("hold_lat_nk6", lat6, 9);
        chki("hold_lat_nk8", lat8, 8);
        rk_idx4 = 4'd10;
        #1;
        chk("hold_nk4_rk10", rk_data4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // asynchronous reset at step 5, then a clean re-key
        rk_idx4 = 4'd0;
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        chk1("pre_rst_busy", busy4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("arst_busy", busy4, 1'b0);
        chk1("arst_busy_nk8", busy8, 1'b0);
        chk1("arst_done", done4, 1'b0);
        chk1("arst_rk_valid", rk_valid4, 1'b0);
        chk("arst_rk_data", rk_data4, 128'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        @(posedge clk);
        #1;
        key4 = '1;
        key6 = '0;
        wait_done(lat4, lat6, lat8);
        chki("rerun_lat_nk4", lat4, 10);
        chki("rerun_lat_nk6", lat6, 8);
        rk_idx4 = 4'd10; rk_idx6 = 4'd12;
        #1;
        chk("rerun_nk4_rk10", rk_data4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("rerun_nk6_rk12", rk_data6, 128'he98ba06f448c773c8ecc720401002202);
        rk_idx4 = 4'd1;
        #1;
        chk("rerun_nk4_rk1", rk_data4, 128'ha0fafe1788542cb123a339392a6c7605);
        key4 = K4;
        key6 = K6;

        // index beyond NR
        rk_idx4 = 4'd15; rk_idx8 = 4'd15;
        #1;
        chk1("idx15_valid", rk_valid4, 1'b0);
        chk("idx15_data", rk_data4, 128'h0);
        chk1("nk8_idx15_valid", rk_valid8, 1'b0);
        rk_idx4 = 4'd11;
        #1;
        chk1("idx11_valid", rk_valid4, 1'b0);
        chk("idx11_data", rk_data4, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
